palette_lookup_arbiter: RTL
===========================

# palette_lookup_arbiter

Shares one palette lookup port (4-bit colour index plus bank select in, 12-bit RGB out) among several sprite renderers: Fireboy, Watergirl, gems, doors. It grants one requester per clock by round-robin and drives the shared index/bank to the external palette mux. It registers the returned colour with the winner's ID. An internal frame-counted flash sequencer can remap a requester's bank to a flash bank for hit/collect blink effects.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- BANK_W, 2, palette bank select width
- FLASH_BANK, 3, bank substituted during flash phase
- FLASH_FRAMES, 8, frame ticks per flash half-period (1..16)

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high
- req  in  NUM_REQ  per-requester lookup request, held until granted
- req_bank  in  NUM_REQ*BANK_W  bank of requester i at bits [i*BANK_W +: BANK_W]
- req_index  in  NUM_REQ*4  colour index of requester i at [i*4 +: 4]
- flash_en  in  NUM_REQ  requester i subject to flash remap
- frame_tick  in  1  one-cycle pulse per video frame
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as req
- pal_bank  out  BANK_W  bank to shared palette mux, combinational
- pal_index  out  4  index to shared palette mux, combinational
- pal_red, pal_green, pal_blue  in  4 each  combinational palette result for pal_bank/pal_index
- rsp_valid  out  1  registered: colour for last cycle's grant
- rsp_id  out  $clog2(NUM_REQ)  requester that owns the response
- red, green, blue  out  4 each  registered colour
- flash_phase  out  1  current flash phase (1 = remap active)

## Operation
- Arbitration: a round-robin pointer `ptr` (reset 0) gives priority order ptr, ptr+1, … NUM_REQ-1, 0, … ptr-1. The first asserted req wins and gets gnt.
- Pointer update: after a grant to k, `ptr` becomes (k+1) mod NUM_REQ. With no request, `ptr` holds and gnt = 0.
- At most one gnt bit per cycle. With no request, pal_index = 0 and pal_bank = 0.
- Bank remap: the winner k presents bank = FLASH_BANK when flash_phase=1 and flash_en[k]=1. Otherwise it presents req_bank of k.
- Index always passes through unmodified.
- Response: on a grant cycle the block registers pal_red/green/blue, winner ID, and rsp_valid=1. With no grant, rsp_valid=0 next cycle. red/green/blue/rsp_id hold their last values.
- Flash sequencer: 4-bit counter `fcnt` (reset 0). On frame_tick:
  - if fcnt == FLASH_FRAMES-1: fcnt := 0 and flash_phase toggles
  - else fcnt increments
- Without a tick, the sequencer holds.
- Requester protocol: a requester keeps req, req_bank and req_index stable until it sees gnt. It may drop req after the grant cycle or keep it for a fresh lookup.

## Timing
- Grant latency: 0 cycles (combinational from req and ptr).
- Response latency: 1 cycle. rsp_valid is high in cycle N+1 for a grant in cycle N.
- Throughput: one lookup per cycle, continuous, no bubbles.
- Fairness: a held request is granted within NUM_REQ cycles.
- A grant and a frame_tick in the same cycle: the lookup uses the pre-tick flash_phase. The new phase applies from the next cycle.
- Reset values: rsp_valid=0, rsp_id=0, red=green=blue=0, flash_phase=0, ptr=0, fcnt=0. gnt/pal_* follow combinationally, so req is granted in the first cycle after reset.
- Reset mid-operation: the pending response is discarded (rsp_valid=0 next cycle) and the flash phase returns to 0.
- FLASH_FRAMES=1: phase toggles on every tick.

## Test plan
- Single requester: req=0001, bank 0, index 5, palette returns F,F,F -> gnt=0001 same cycle; next cycle rsp_valid=1, rsp_id=0, rgb=F,F,F.
- All four requesting continuously for 8 cycles -> grants 0,1,2,3,0,1,2,3; rsp_id follows the same sequence one cycle later; rsp_valid stays 1.
- Pointer wrap: grant to 3, then req=1001 -> requester 0 wins; then req=1000 -> 3 wins.
- Flash, FLASH_FRAMES=2, flash_en=0001: after 2 ticks flash_phase=1 and requester 0's pal_bank=3 while requester 1 keeps its own bank; after 2 more ticks flash_phase=0.
- Tick and grant in the same cycle at the phase boundary -> that lookup uses the old bank; the next lookup uses the remapped bank.
- Reset asserted the cycle after a grant -> rsp_valid=0, rgb=0, ptr=0, flash_phase=0; the first grant after release goes to the lowest asserted requester.

Source files
------------

// File: rtl/palette_lookup_arbiter.sv
// Round-robin arbiter sharing one palette lookup port among sprite renderers,
// with a frame-counted flash sequencer that can swap a requester's bank for blink effects.
module palette_lookup_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BANK_W       = 2,
  parameter int FLASH_BANK   = 3,
  parameter int FLASH_FRAMES = 8
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*BANK_W-1:0]    req_bank,
  input  logic [NUM_REQ*4-1:0]         req_index,
  input  logic [NUM_REQ-1:0]           flash_en,
  input  logic                         frame_tick,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [BANK_W-1:0]            pal_bank,
  output logic [3:0]                   pal_index,
  input  logic [3:0]                   pal_red,
  input  logic [3:0]                   pal_green,
  input  logic [3:0]                   pal_blue,
  output logic                         rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
  output logic [3:0]                   red,
  output logic [3:0]                   green,
  output logic [3:0]                   blue,
  output logic                         flash_phase
);

  localparam int                ID_W         = $clog2(NUM_REQ);
  localparam logic [BANK_W-1:0] FLASH_BANK_V = BANK_W'(FLASH_BANK);
  localparam logic [3:0]        FCNT_LAST    = 4'(FLASH_FRAMES - 1);
  localparam logic [ID_W-1:0]   LAST_ID      = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [3:0]      fcnt_q, fcnt_d;
  logic            phase_q, phase_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [11:0]     rgb_q, rgb_d;

  logic            found;
  logic [ID_W-1:0] win_id;
  int              cand;

  // Scan from the pointer upward with wraparound; the first asserted request wins.
  always_comb begin
    found  = 1'b0;
    win_id = '0;
    cand   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req[cand]) begin
        found  = 1'b1;
        win_id = ID_W'(cand);
      end
    end
  end

  always_comb begin
    gnt       = '0;
    pal_bank  = '0;
    pal_index = '0;
    if (found) begin
      gnt[win_id] = 1'b1;
      pal_index   = req_index[win_id*4 +: 4];
      pal_bank    = req_bank[win_id*BANK_W +: BANK_W];
      if (phase_q && flash_en[win_id]) pal_bank = FLASH_BANK_V;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (found) ptr_d = (win_id == LAST_ID) ? '0 : win_id + 1'b1;

    fcnt_d  = fcnt_q;
    phase_d = phase_q;
    if (frame_tick) begin
      if (fcnt_q == FCNT_LAST) begin
        fcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        fcnt_d = fcnt_q + 4'd1;
      end
    end

    rsp_valid_d = found;
    rsp_id_d    = rsp_id_q;
    rgb_d       = rgb_q;
    if (found) begin
      rsp_id_d = win_id;
      rgb_d    = {pal_red, pal_green, pal_blue};
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ptr_q       <= '0;
      fcnt_q      <= '0;
      phase_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rgb_q       <= '0;
    end else begin
      ptr_q       <= ptr_d;
      fcnt_q      <= fcnt_d;
      phase_q     <= phase_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rgb_q       <= rgb_d;
    end
  end

  assign rsp_valid             = rsp_valid_q;
  assign rsp_id                = rsp_id_q;
  assign {red, green, blue}    = rgb_q;
  assign flash_phase           = phase_q;

endmodule
